filter_out_stage: RTL and testbench

Output stage directly downstream of the 8-bit state-variable filter. Each sample it selects and sums the filter's HP/BP/LP taps with the unfiltered voice bus, saturates the sum, applies a 4-bit master volume and registers the result. It converts that sample to a 1-bit PWM audio pin. It also generates the `sample_valid` strobe that advances the filter state, so filter and output stay sample-aligned.

---
 rtl/filter_out_stage_if.sv | 24 ++
 rtl/filter_out_stage.sv | 97 +++++++++
 tb/tb_filter_out_stage.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/filter_out_stage_if.sv
`timescale 1ns/1ps
// Signal bundle between the state-variable filter and its output stage.
// The master side drives the taps and controls; the slave side is the output stage.
interface filter_out_stage_if;
  logic signed [7:0] filt_hp;
  logic signed [7:0] filt_bp;
  logic signed [7:0] filt_lp;
  logic signed [7:0] bypass_in;
  logic        [2:0] mode;
  logic        [3:0] volume;
  logic              sample_valid;
  logic signed [7:0] sample_out;
  logic              pwm_out;

  modport master (
    output filt_hp, filt_bp, filt_lp, bypass_in, mode, volume,
    input  sample_valid, sample_out, pwm_out
  );

  modport slave (
    input  filt_hp, filt_bp, filt_lp, bypass_in, mode, volume,
    output sample_valid, sample_out, pwm_out
  );
endinterface

// File: rtl/filter_out_stage.sv
`timescale 1ns/1ps
// Filter output stage: tap mix, saturation, master volume, sample register,
// 1-bit PWM audio pin and the sample strobe that steps the filter.
module filter_out_stage #(
  parameter int CLK_DIV = 256
) (
  input  logic           clk,
  input  logic           rst,
  filter_out_stage_if.slave bus
);

  localparam int DATA_W = 8;
  localparam int MIX_W  = 10;
  localparam int TICK_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic        [TICK_W-1:0] tick_cnt;
  logic                     vld_p0;
  logic signed [MIX_W-1:0]  mix_p0;
  logic signed [DATA_W-1:0] sat_p0;
  logic signed [DATA_W-1:0] scaled_p0;
  logic signed [DATA_W-1:0] sample_p1;
  logic        [7:0]        pwm_cnt;
  logic        [7:0]        duty;
  logic                     pwm_p1;

  function automatic logic signed [MIX_W-1:0] ext_tap(input logic signed [DATA_W-1:0] x);
    return {{(MIX_W-DATA_W){x[DATA_W-1]}}, x};
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_mix(input logic signed [MIX_W-1:0] s);
    if (s > 10'sd127)
      return 8'sd127;
    else if (s < -10'sd128)
      return -8'sd128;
    else
      return $signed(s[DATA_W-1:0]);
  endfunction

  // Gain is volume/16; floor shift keeps negative samples rounding toward -inf.
  function automatic logic signed [DATA_W-1:0] scale_vol(input logic signed [DATA_W-1:0] s,
                                                          input logic        [3:0]        v);
    logic signed [12:0] prod;
    logic signed [12:0] shifted;
    prod    = $signed({{5{s[DATA_W-1]}}, s}) * $signed({9'b0, v});
    shifted = prod >>> 4;
    return $signed(shifted[DATA_W-1:0]);
  endfunction

  // ---- stage p0: sample tick, tap mix, saturation, volume ----
  assign vld_p0 = (tick_cnt == TICK_W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst)
      tick_cnt <= '0;
    else if (vld_p0)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + TICK_W'(1);
  end

  always_comb begin
    mix_p0 = ext_tap(bus.bypass_in);
    if (bus.mode[0]) mix_p0 = mix_p0 + ext_tap(bus.filt_lp);
    if (bus.mode[1]) mix_p0 = mix_p0 + ext_tap(bus.filt_bp);
    if (bus.mode[2]) mix_p0 = mix_p0 + ext_tap(bus.filt_hp);
  end

  assign sat_p0    = sat_mix(mix_p0);
  assign scaled_p0 = scale_vol(sat_p0, bus.volume);

  // ---- stage p1: sample register, captured on the same edge the filter advances ----
  always_ff @(posedge clk) begin
    if (rst)
      sample_p1 <= '0;
    else if (vld_p0)
      sample_p1 <= scaled_p0;
  end

  // PWM duty reloads only at the period boundary, from the sample already held.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
      duty    <= 8'h80;
      pwm_p1  <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (pwm_cnt == 8'hFF)
        duty <= 8'(sample_p1) ^ 8'h80;
      pwm_p1 <= (pwm_cnt < duty);
    end
  end

  assign bus.sample_valid = vld_p0;
  assign bus.sample_out   = sample_p1;
  assign bus.pwm_out      = pwm_p1;

endmodule

// File: tb/tb_filter_out_stage.sv
`timescale 1ns/1ps
// Directed bench for filter_out_stage: one instance at CLK_DIV=8 for the mix
// and PWM vectors, one at CLK_DIV=256 for the boundary collision and mid-run reset.
module tb_filter_out_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  filter_out_stage_if bus8();
  filter_out_stage_if bus256();

  filter_out_stage #(.CLK_DIV(8))   dut8   (.clk(clk), .rst(rst), .bus(bus8));
  filter_out_stage #(.CLK_DIV(256)) dut256 (.clk(clk), .rst(rst), .bus(bus256));

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic signed [7:0] hp, input logic signed [7:0] bp,
                        input logic signed [7:0] lp, input logic signed [7:0] byp,
                        input logic [2:0] m, input logic [3:0] v);
    bus8.filt_hp   = hp;  bus256.filt_hp   = hp;
    bus8.filt_bp   = bp;  bus256.filt_bp   = bp;
    bus8.filt_lp   = lp;  bus256.filt_lp   = lp;
    bus8.bypass_in = byp; bus256.bypass_in = byp;
    bus8.mode      = m;   bus256.mode      = m;
    bus8.volume    = v;   bus256.volume    = v;
  endtask

  // Cycles until the chosen instance shows sample_valid at a falling edge, -1 on timeout.
  task automatic wait_strobe(input bit big, input int limit, output int cycles);
    cycles = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ((big ? bus256.sample_valid : bus8.sample_valid) == 1'b1) begin
        cycles = i + 1;
        break;
      end
    end
  endtask

  task automatic capture8(input string tag, input int exp);
    int c;
    wait_strobe(1'b0, 20, c);
    chk({tag, "_strobe_seen"}, (c > 0) ? 1 : 0, 1);
    chk({tag, "_pre_capture"}, (c > 0 && bus8.sample_out !== exp) ? 1 : 0, 1);
    @(negedge clk);
    chk(tag, bus8.sample_out, exp);
  endtask

  task automatic measure_pwm(input string tag, input int exp_duty);
    int hi;
    int guard;
    guard = 0;
    @(negedge clk);
    while (dut8.pwm_cnt != 8'hFF && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_boundary"}, (guard < 300) ? 1 : 0, 1);
    @(negedge clk);
    chk({tag, "_duty"}, dut8.duty, exp_duty);
    hi = 0;
    repeat (256) begin
      @(negedge clk);
      hi += int'(bus8.pwm_out);
    end
    chk({tag, "_high_cycles"}, hi, exp_duty);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi;
    int c;
    int guard;

    rst = 1'b1;
    set_in(0, 0, 0, 0, 3'b000, 4'd0);
    repeat (3) @(negedge clk);

    chk("rst_sample8",   bus8.sample_out,     0);
    chk("rst_sample256", bus256.sample_out,   0);
    chk("rst_valid8",    bus8.sample_valid,   0);
    chk("rst_pwm8",      bus8.pwm_out,        0);
    chk("rst_duty8",     dut8.duty,           128);
    chk("rst_tick256",   dut256.tick_cnt,     0);
    chk("rst_pwmcnt8",   dut8.pwm_cnt,        0);

    // Strobe cadence and the silent 50 % PWM period straight out of reset.
    rst = 1'b0;
    hi  = 0;
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      if (k <= 32) chk("strobe8", bus8.sample_valid, (k % 8 == 7) ? 1 : 0);
      if (k == 254 || k == 255) chk("strobe256", bus256.sample_valid, (k == 255) ? 1 : 0);
      hi += int'(bus8.pwm_out);
    end
    chk("pwm_reset_high", hi, 128);

    set_in(-128, 100, 100, 0, 3'b011, 4'd15);
    capture8("pos_sat", 119);
    measure_pwm("pwm_119", 247);

    set_in(-128, 100, 100, -128, 3'b100, 4'd15);
    capture8("neg_sat", -120);
    measure_pwm("pwm_m120", 8);

    set_in(-128, 0, 0, -1, 3'b000, 4'd1);
    capture8("floor", -1);
    set_in(-128, 0, 0, -1, 3'b000, 4'd0);
    capture8("vol_zero", 0);
    set_in(30, 20, 10, -5, 3'b111, 4'd8);
    capture8("all_taps", 27);
    set_in(30, 20, 10, 64, 3'b000, 4'd15);
    capture8("bypass_only", 60);

    // Boundary collision on the CLK_DIV=256 instance.
    rst = 1'b1;
    set_in(0, 0, 0, 64, 3'b000, 4'd15);
    @(negedge clk);
    rst = 1'b0;
    wait_strobe(1'b1, 300, c);
    chk("coll1_cycles", c, 255);
    chk("coll1_pwmcnt", dut256.pwm_cnt, 255);
    @(negedge clk);
    chk("coll1_sample", bus256.sample_out, 60);
    chk("coll1_duty",   dut256.duty,       128);

    set_in(0, 0, 0, -64, 3'b000, 4'd15);
    wait_strobe(1'b1, 300, c);
    chk("coll2_cycles", c, 255);
    @(negedge clk);
    chk("coll2_sample", bus256.sample_out, -60);
    chk("coll2_duty",   dut256.duty,       188);

    set_in(0, 100, 100, 0, 3'b011, 4'd15);
    wait_strobe(1'b1, 300, c);
    chk("coll3_cycles", c, 255);
    @(negedge clk);
    chk("coll3_sample", bus256.sample_out, 119);
    chk("coll3_duty",   dut256.duty,       68);

    // Reset in the middle of a sample period.
    guard = 0;
    while (dut256.tick_cnt != 8'd100 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk("midrst_reach_tick", (guard < 300) ? 1 : 0, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_sample", bus256.sample_out, 0);
    chk("midrst_duty",   dut256.duty,       128);
    chk("midrst_tick",   dut256.tick_cnt,   0);
    chk("midrst_pwmcnt", dut256.pwm_cnt,    0);
    chk("midrst_pwm",    bus256.pwm_out,    0);
    chk("midrst_valid",  bus256.sample_valid, 0);
    wait_strobe(1'b1, 300, c);
    chk("midrst_resume", c, 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
